// File: rtl/exit_wb_arbiter.sv
// Write-back scheduler for the 8-entry EXIT register bank.
// Arbitrates A/B requests, then runs a setup cycle and a one-cycle ld strobe.
//
// Ports:
//   clk, reset            clock, async active-low reset
//   a_valid/a_ready       requester A handshake (ready is combinational)
//   a_data/a_dest         requester A write payload
//   b_valid/b_ready       requester B handshake (ready is combinational)
//   b_data/b_dest         requester B write payload
//   wb_data/wb_dest/wb_ld registered bank write bus and ld strobe
//   pending               one-hot of the held dest while busy, else 0
//   busy                  FSM not idle
module exit_wb_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEST_W = 3,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [DATA_W-1:0]        a_data,
    input  logic [DEST_W-1:0]        a_dest,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [DATA_W-1:0]        b_data,
    input  logic [DEST_W-1:0]        b_dest,
    output logic [DATA_W-1:0]        wb_data,
    output logic [DEST_W-1:0]        wb_dest,
    output logic                     wb_ld,
    output logic [(1<<DEST_W)-1:0]   pending,
    output logic                     busy
);

    localparam int NB = 1 << DEST_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic              ld_q, ld_d;
    logic              prefb_q, prefb_d;

    logic              open_w;
    logic              pick_b;
    logic              grant_a;
    logic              grant_b;

    // A new write can be taken while idle, or in the strobe cycle so that
    // back-to-back writes run SETUP/STROBE with no bubble.
    assign open_w  = (state_q == S_IDLE) || (state_q == S_STROBE);

    // B wins when it is alone, or when both ask and the pointer favours B.
    assign pick_b  = b_valid & (~a_valid | (RR_EN & prefb_q));
    assign grant_a = open_w & a_valid & ~pick_b;
    assign grant_b = open_w & pick_b;

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dest_d  = dest_q;
        prefb_d = prefb_q;
        case (state_q)
            S_IDLE: begin
                if (grant_a || grant_b) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
            end
            S_STROBE: begin
                state_d = (grant_a || grant_b) ? S_SETUP : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Capture may coincide with ld falling; the bank only uses the rise.
        if (grant_a) begin
            data_d  = a_data;
            dest_d  = a_dest;
            prefb_d = 1'b1;
        end else if (grant_b) begin
            data_d  = b_data;
            dest_d  = b_dest;
            prefb_d = 1'b0;
        end
        // ld is a flop output, so the bank sees a clean single pulse.
        ld_d = (state_d == S_STROBE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            dest_q  <= '0;
            ld_q    <= 1'b0;
            prefb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            ld_q    <= ld_d;
            prefb_q <= prefb_d;
        end
    end

    assign wb_data = data_q;
    assign wb_dest = dest_q;
    assign wb_ld   = ld_q;
    assign busy    = (state_q != S_IDLE);
    assign pending = busy ? ({{(NB-1){1'b0}}, 1'b1} << dest_q) : '0;

endmodule

// File: tb/tb_exit_wb_arbiter.sv
// Self-checking bench for exit_wb_arbiter.
// Random and directed traffic against a cycle-level arbitration/bank model.
module tb_exit_wb_arbiter;

    typedef struct {
        logic [7:0] d;
        logic [2:0] t;
    } req_t;

    typedef struct {
        int         c;
        logic [7:0] d;
        logic [2:0] t;
    } ld_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic [2:0] a_dest, b_dest;

    logic       r_a_ready, r_b_ready, r_wb_ld, r_busy;
    logic [7:0] r_wb_data, r_pending;
    logic [2:0] r_wb_dest;

    logic       f_a_ready, f_b_ready, f_wb_ld, f_busy;
    logic [7:0] f_wb_data, f_pending;
    logic [2:0] f_wb_dest;

    int n_tests = 0;
    int n_fail  = 0;

    req_t qa[$];
    req_t qb[$];
    ld_t  ldq[$];
    int   glog[$];

    logic [7:0] rbank[8];
    logic [7:0] dbank[8];

    int   cyc = 0;
    int   last_g = -100;
    bit   pref_b = 0;
    logic [2:0] last_dest = '0;
    bit   sel_fp = 0;
    bit   stress = 0;
    logic prev_ld = 0;
    logic [7:0] prev_data = '0;
    logic [2:0] prev_dest = '0;
    int   ld_rises = 0;
    int   fa_cnt = 0;
    int   fb_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge r_wb_ld) ld_rises++;

    exit_wb_arbiter #(.DATA_W(8), .DEST_W(3), .RR_EN(1'b1)) u_rr (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(r_a_ready),
        .a_data(a_data), .a_dest(a_dest),
        .b_valid(b_valid), .b_ready(r_b_ready),
        .b_data(b_data), .b_dest(b_dest),
        .wb_data(r_wb_data), .wb_dest(r_wb_dest), .wb_ld(r_wb_ld),
        .pending(r_pending), .busy(r_busy)
    );

    exit_wb_arbiter #(.DATA_W(8), .DEST_W(3), .RR_EN(1'b0)) u_fp (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(f_a_ready),
        .a_data(a_data), .a_dest(a_dest),
        .b_valid(b_valid), .b_ready(f_b_ready),
        .b_data(b_data), .b_dest(b_dest),
        .wb_data(f_wb_data), .wb_dest(f_wb_dest), .wb_ld(f_wb_ld),
        .pending(f_pending), .busy(f_busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        a_valid = (qa.size() != 0);
        b_valid = (qb.size() != 0);
        if (a_valid) begin
            a_data = qa[0].d;
            a_dest = qa[0].t;
        end else begin
            a_data = 8'($urandom);
            a_dest = 3'($urandom);
        end
        if (b_valid) begin
            b_data = qb[0].d;
            b_dest = qb[0].t;
        end else begin
            b_data = 8'($urandom);
            b_dest = 3'($urandom);
        end
    endtask

    // Model: a grant is possible once 2 cycles have passed since the last
    // one; the write strobes 2 cycles after its grant.
    task automatic model_check();
        bit ea, eb, bz, eld;
        int d;
        ea = 0;
        eb = 0;
        d = cyc - last_g;
        bz = (d == 1) || (d == 2);
        check("busy", {31'd0, r_busy}, {31'd0, bz});
        check("pending", {24'd0, r_pending},
              bz ? (32'd1 << last_dest) : 32'd0);
        if (d >= 2) begin
            if (a_valid && b_valid) begin
                if (pref_b) eb = 1; else ea = 1;
            end else if (a_valid) begin
                ea = 1;
            end else if (b_valid) begin
                eb = 1;
            end
        end
        check("a_ready", {31'd0, r_a_ready}, {31'd0, ea});
        check("b_ready", {31'd0, r_b_ready}, {31'd0, eb});
        check("one_ready", {31'd0, r_a_ready & r_b_ready}, 32'd0);
        if (ea || eb) begin
            last_g = cyc;
            pref_b = ea;
            last_dest = ea ? a_dest : b_dest;
            ldq.push_back('{cyc + 2, ea ? a_data : b_data, last_dest});
        end
        eld = (ldq.size() != 0) && (ldq[0].c == cyc);
        check("wb_ld", {31'd0, r_wb_ld}, {31'd0, eld});
        if (eld) begin
            check("wb_data", {24'd0, r_wb_data}, {24'd0, ldq[0].d});
            check("wb_dest", {29'd0, r_wb_dest}, {29'd0, ldq[0].t});
            rbank[ldq[0].t] = ldq[0].d;
            void'(ldq.pop_front());
        end
        // The bank captures on the rising ld edge what was set up before it.
        if (r_wb_ld && !prev_ld) begin
            check("stable", {21'd0, r_wb_data, r_wb_dest},
                  {21'd0, prev_data, prev_dest});
            dbank[prev_dest] = prev_data;
        end
        prev_ld = r_wb_ld;
        prev_data = r_wb_data;
        prev_dest = r_wb_dest;
    endtask

    task automatic step();
        bit acc_a, acc_b;
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        if (!sel_fp) model_check();
        if (sel_fp) begin
            if (f_a_ready) fa_cnt++;
            if (f_b_ready) fb_cnt++;
        end
        acc_a = sel_fp ? f_a_ready : r_a_ready;
        acc_b = sel_fp ? f_b_ready : r_b_ready;
        if (a_valid && acc_a) begin
            void'(qa.pop_front());
            glog.push_back(0);
        end
        if (b_valid && acc_b) begin
            void'(qb.pop_front());
            glog.push_back(1);
        end
        if (stress) begin
            if (qa.size() < 2 && $urandom_range(0, 2) == 0)
                qa.push_back('{8'($urandom), 3'($urandom)});
            if (qb.size() < 2 && $urandom_range(0, 2) == 0)
                qb.push_back('{8'($urandom), 3'($urandom)});
        end
        cyc++;
    endtask

    task automatic do_reset();
        qa.delete();
        qb.delete();
        ldq.delete();
        glog.delete();
        drive();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ld", {31'd0, r_wb_ld}, 32'd0);
        check("rst_data", {24'd0, r_wb_data}, 32'd0);
        check("rst_dest", {29'd0, r_wb_dest}, 32'd0);
        check("rst_pend", {24'd0, r_pending}, 32'd0);
        check("rst_busy", {31'd0, r_busy}, 32'd0);
        last_g = -100;
        pref_b = 0;
        prev_ld = 0;
        prev_data = '0;
        prev_dest = '0;
        reset = 1'b1;
    endtask

    initial begin
        int r0;
        for (int i = 0; i < 8; i++) begin
            rbank[i] = '0;
            dbank[i] = '0;
        end
        reset = 1'b0;
        a_valid = 0;
        b_valid = 0;
        a_data = '0;
        b_data = '0;
        a_dest = '0;
        b_dest = '0;
        do_reset();

        // Reset in the middle of SETUP drops the write.
        qa.push_back('{8'h5A, 3'd3});
        step();
        r0 = ld_rises;
        @(posedge clk);
        #2;
        check("t1_setup", {31'd0, r_busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("t1_ld", {31'd0, r_wb_ld}, 32'd0);
        check("t1_data", {24'd0, r_wb_data}, 32'd0);
        check("t1_dest", {29'd0, r_wb_dest}, 32'd0);
        check("t1_busy", {31'd0, r_busy}, 32'd0);
        do_reset();
        repeat (3) step();
        check("t1_norise", ld_rises, r0);

        // Single A write: timing and pending.
        qa.push_back('{8'h12, 3'd5});
        step();
        step();
        check("t2_pend1", {24'd0, r_pending}, 32'h20);
        check("t2_ld1", {31'd0, r_wb_ld}, 32'd0);
        step();
        check("t2_pend2", {24'd0, r_pending}, 32'h20);
        check("t2_ld2", {31'd0, r_wb_ld}, 32'd1);
        check("t2_data", {24'd0, r_wb_data}, 32'h12);
        check("t2_dest", {29'd0, r_wb_dest}, 32'd5);
        step();
        check("t2_ld3", {31'd0, r_wb_ld}, 32'd0);
        check("t2_pend3", {24'd0, r_pending}, 32'd0);

        // Round-robin with both requesters loaded.
        do_reset();
        r0 = ld_rises;
        qa.push_back('{8'hA1, 3'd0});
        qa.push_back('{8'hA2, 3'd1});
        qb.push_back('{8'hB1, 3'd6});
        qb.push_back('{8'hB2, 3'd7});
        repeat (10) step();
        check("t3_ngrant", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            check("t3_order", glog[i], i % 2);
        check("t3_nld", ld_rises - r0, 4);

        // Fixed priority starves B.
        do_reset();
        sel_fp = 1;
        fa_cnt = 0;
        fb_cnt = 0;
        for (int i = 0; i < 8; i++) qa.push_back('{8'(i), 3'(i)});
        qb.push_back('{8'hEE, 3'd1});
        repeat (10) step();
        check("t4_a", fa_cnt, 5);
        check("t4_b", fb_cnt, 0);
        sel_fp = 0;

        // Same dest from A then B; later write wins.
        do_reset();
        r0 = ld_rises;
        qa.push_back('{8'h11, 3'd2});
        step();
        qb.push_back('{8'h22, 3'd2});
        repeat (6) step();
        check("t5_nld", ld_rises - r0, 2);
        check("t5_bank", {24'd0, dbank[2]}, 32'h22);
        check("t5_ref", {24'd0, rbank[2]}, 32'h22);

        // Random stress.
        do_reset();
        stress = 1;
        repeat (1500) step();
        stress = 0;
        repeat (20) step();
        for (int i = 0; i < 8; i++)
            check("t6_bank", {24'd0, dbank[i]}, {24'd0, rbank[i]});
        check("t6_drain", ldq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
